gol_controller: RTL and testbench

- Top-level sequencer for the Game-of-Life board. Scans the 4x4 keypad with a settle delay and debounces each key into one-shot key events.
- Interprets each event as a user command: pattern select, run/pause, single step, speed change or clear.
- Issues LOAD/STEP/CLEAR commands to the board engine over a single req/ack handshake.
- Paces automatic generations with a speed-selectable step timer.

---
 rtl/gol_pkg.sv | 43 ++++
 rtl/gol_controller_keypad_debounce.sv | 101 ++++++++++
 rtl/gol_controller.sv | 193 +++++++++++++++++++
 tb/tb_gol_controller.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared encodings for the Game-of-Life controller: command ops, key codes,
// keypad position decode and reset speed.
package gol_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STEP  = 2'd1,
    OP_CLEAR = 2'd2
  } cmd_op_e;

  localparam logic [3:0] KEY_RUN   = 4'hA;
  localparam logic [3:0] KEY_STEP  = 4'hB;
  localparam logic [3:0] KEY_FAST  = 4'hC;
  localparam logic [3:0] KEY_SLOW  = 4'hD;
  localparam logic [3:0] KEY_CLEAR = 4'hE;

  localparam logic [2:0] SPEED_RESET = 3'd3;

  // row/col are the bit positions of the low line on the row drive / column sense
  function automatic logic [3:0] key_decode(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b11_11: code = 4'hF;
      4'b11_10: code = 4'hE;
      4'b11_01: code = 4'hD;
      4'b11_00: code = 4'hC;
      4'b10_11: code = 4'hB;
      4'b10_10: code = 4'h3;
      4'b10_01: code = 4'h6;
      4'b10_00: code = 4'h9;
      4'b01_11: code = 4'hA;
      4'b01_10: code = 4'h2;
      4'b01_01: code = 4'h5;
      4'b01_00: code = 4'h8;
      4'b00_11: code = 4'h0;
      4'b00_10: code = 4'h1;
      4'b00_01: code = 4'h4;
      default:  code = 4'h7;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/gol_controller_keypad_debounce.sv
// 4x4 keypad scanner: rotates the low row every SCAN_DIV cycles, debounces
// each key over DEB_N visits and emits one-shot press events.
module keypad_debounce
  import gol_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEB_N    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n_i,
  output logic [3:0] row_n_o,
  output logic       key_evt_o,
  output logic [3:0] key_code_o
);

  localparam int unsigned   SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB_LIM   = 4'(DEB_N);

  logic [SW-1:0] scan_q, scan_d;
  logic [3:0]    row_q, row_d;
  logic [15:0]   stable_q, stable_d;
  logic [3:0]    cnt_q [16];
  logic [3:0]    cnt_d [16];
  logic          evt_q, evt_d;
  logic [3:0]    code_q, code_d;
  logic [1:0]    row_idx;
  logic [3:0]    k;
  logic [3:0]    kc;
  logic          pressed;

  always_comb begin
    case (row_q)
      4'b0111: row_idx = 2'd3;
      4'b1011: row_idx = 2'd2;
      4'b1101: row_idx = 2'd1;
      default: row_idx = 2'd0;
    endcase
  end

  always_comb begin
    scan_d   = scan_q + SW'(1);
    row_d    = row_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    evt_d    = 1'b0;
    code_d   = code_q;
    k        = '0;
    kc       = '0;
    pressed  = 1'b0;
    if (scan_q == SLOT_LAST) begin
      scan_d = '0;
      row_d  = {row_q[0], row_q[3:1]};
      // Only the lowest code among simultaneous flips is reported; the rest
      // still latch their new stable state.
      for (int unsigned c = 0; c < 4; c++) begin
        k       = {row_idx, 2'(c)};
        kc      = key_decode(row_idx, 2'(c));
        pressed = !col_n_i[c];
        if (pressed != stable_q[k]) begin
          if (cnt_q[k] + 4'd1 == DEB_LIM) begin
            stable_d[k] = pressed;
            cnt_d[k]    = '0;
            if (pressed && (!evt_d || kc < code_d)) begin
              evt_d  = 1'b1;
              code_d = kc;
            end
          end else begin
            cnt_d[k] = cnt_q[k] + 4'd1;
          end
        end else begin
          cnt_d[k] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_q   <= '0;
      row_q    <= 4'b1110;
      stable_q <= '0;
      cnt_q    <= '{default: '0};
      evt_q    <= 1'b0;
      code_q   <= '0;
    end else begin
      scan_q   <= scan_d;
      row_q    <= row_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
      code_q   <= code_d;
    end
  end

  assign row_n_o    = row_q;
  assign key_evt_o  = evt_q;
  assign key_code_o = code_q;

endmodule

// File: rtl/gol_controller.sv
// Game-of-Life sequencer: turns keypad events into LOAD/STEP/CLEAR commands
// for the board engine and paces automatic generations.
module gol_controller
  import gol_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 1000,
  parameter int unsigned DEB_N       = 4,
  parameter int unsigned BASE_PERIOD = 1000000,
  parameter int unsigned GEN_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       keypadCol,
  output logic [3:0]       keypadRow,
  output logic             cmd_req,
  output logic [1:0]       cmd_op,
  output logic [3:0]       cmd_pattern,
  input  logic             cmd_ack,
  output logic             running,
  output logic [2:0]       speed,
  output logic [GEN_W-1:0] gen_count
);

  typedef enum logic {ST_READY, ST_BUSY} state_e;

  localparam int unsigned   PW         = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(BASE_PERIOD - 1);

  state_e           state_q, state_d;
  logic             key_evt;
  logic [3:0]       key_code;
  logic             pend_load_q, pend_load_d;
  logic             pend_step_q, pend_step_d;
  logic             pend_clear_q, pend_clear_d;
  logic [3:0]       pattern_q, pattern_d;
  logic             running_q, running_d;
  logic [2:0]       speed_q, speed_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [3:0]       tick_q, tick_d;
  logic [3:0]       period_q, period_d;
  logic             cmd_req_q, cmd_req_d;
  cmd_op_e          op_q, op_d;
  logic [3:0]       cmd_pat_q, cmd_pat_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             fire, step_key, step_kill;

  keypad_debounce #(
    .SCAN_DIV (SCAN_DIV),
    .DEB_N    (DEB_N)
  ) u_keypad (
    .clk        (clk),
    .rst        (rst),
    .col_n_i    (keypadCol),
    .row_n_o    (keypadRow),
    .key_evt_o  (key_evt),
    .key_code_o (key_code)
  );

  always_comb begin
    state_d      = state_q;
    pend_load_d  = pend_load_q;
    pend_step_d  = pend_step_q;
    pend_clear_d = pend_clear_q;
    pattern_d    = pattern_q;
    running_d    = running_q;
    speed_d      = speed_q;
    presc_d      = presc_q;
    tick_d       = tick_q;
    period_d     = period_q;
    cmd_req_d    = cmd_req_q;
    op_d         = op_q;
    cmd_pat_d    = cmd_pat_q;
    gen_d        = gen_q;
    fire         = 1'b0;
    step_key     = 1'b0;
    step_kill    = 1'b0;

    case (state_q)
      ST_READY: begin
        if (pend_clear_q || pend_load_q || pend_step_q) begin
          cmd_req_d = 1'b1;
          state_d   = ST_BUSY;
          if (pend_clear_q) begin
            op_d         = OP_CLEAR;
            cmd_pat_d    = '0;
            pend_clear_d = 1'b0;
          end else if (pend_load_q) begin
            op_d        = OP_LOAD;
            cmd_pat_d   = pattern_q;
            pend_load_d = 1'b0;
          end else begin
            op_d        = OP_STEP;
            cmd_pat_d   = '0;
            pend_step_d = 1'b0;
          end
        end
      end
      ST_BUSY: begin
        if (cmd_ack) begin
          cmd_req_d = 1'b0;
          state_d   = ST_READY;
          gen_d     = (op_q == OP_STEP) ? gen_q + GEN_W'(1) : '0;
        end
      end
    endcase

    if (key_evt) begin
      if (key_code <= 4'd9) begin
        pend_load_d = 1'b1;
        pattern_d   = key_code;
        running_d   = 1'b0;
        step_kill   = 1'b1;
      end else begin
        case (key_code)
          KEY_RUN:   running_d = !running_q;
          KEY_STEP:  step_key  = !running_q;
          KEY_FAST:  if (speed_q != 3'd7) speed_d = speed_q + 3'd1;
          KEY_SLOW:  if (speed_q != 3'd0) speed_d = speed_q - 3'd1;
          KEY_CLEAR: begin
            pend_clear_d = 1'b1;
            pend_load_d  = 1'b0;
            running_d    = 1'b0;
            step_kill    = 1'b1;
          end
          default: ;
        endcase
      end
    end

    // Period is latched only at restart so a speed change waits for the next boundary.
    if (!running_d) begin
      presc_d  = '0;
      tick_d   = '0;
      period_d = 4'd8 - {1'b0, speed_d};
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      if (tick_q == period_q - 4'd1) begin
        fire     = 1'b1;
        tick_d   = '0;
        period_d = 4'd8 - {1'b0, speed_q};
      end else begin
        tick_d = tick_q + 4'd1;
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (fire || step_key) pend_step_d = 1'b1;
    if (step_kill)        pend_step_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_READY;
      pend_load_q  <= 1'b0;
      pend_step_q  <= 1'b0;
      pend_clear_q <= 1'b0;
      pattern_q    <= '0;
      running_q    <= 1'b0;
      speed_q      <= SPEED_RESET;
      presc_q      <= '0;
      tick_q       <= '0;
      period_q     <= 4'd8 - {1'b0, SPEED_RESET};
      cmd_req_q    <= 1'b0;
      op_q         <= OP_LOAD;
      cmd_pat_q    <= '0;
      gen_q        <= '0;
    end else begin
      state_q      <= state_d;
      pend_load_q  <= pend_load_d;
      pend_step_q  <= pend_step_d;
      pend_clear_q <= pend_clear_d;
      pattern_q    <= pattern_d;
      running_q    <= running_d;
      speed_q      <= speed_d;
      presc_q      <= presc_d;
      tick_q       <= tick_d;
      period_q     <= period_d;
      cmd_req_q    <= cmd_req_d;
      op_q         <= op_d;
      cmd_pat_q    <= cmd_pat_d;
      gen_q        <= gen_d;
    end
  end

  assign cmd_req     = cmd_req_q;
  assign cmd_op      = op_q;
  assign cmd_pattern = cmd_pat_q;
  assign running     = running_q;
  assign speed       = speed_q;
  assign gen_count   = gen_q;

endmodule

// File: tb/tb_gol_controller.sv
// Scoreboard bench for gol_controller: a keypad model presses keys, expected
// commands are queued on stimulus and matched when cmd_req rises.
module tb_gol_controller;

  localparam int unsigned GEN_W = 16;
  localparam logic [1:0]  E_LOAD  = 2'd0;
  localparam logic [1:0]  E_STEP  = 2'd1;
  localparam logic [1:0]  E_CLEAR = 2'd2;

  typedef struct {
    logic [1:0] op;
    logic [3:0] pat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [3:0]       keypadCol;
  logic [3:0]       keypadRow;
  logic             cmd_req;
  logic [1:0]       cmd_op;
  logic [3:0]       cmd_pattern;
  logic             cmd_ack = 1'b0;
  logic             running;
  logic [2:0]       speed;
  logic [GEN_W-1:0] gen_count;

  gol_controller #(
    .SCAN_DIV    (4),
    .DEB_N       (2),
    .BASE_PERIOD (10),
    .GEN_W       (GEN_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .keypadCol   (keypadCol),
    .keypadRow   (keypadRow),
    .cmd_req     (cmd_req),
    .cmd_op      (cmd_op),
    .cmd_pattern (cmd_pattern),
    .cmd_ack     (cmd_ack),
    .running     (running),
    .speed       (speed),
    .gen_count   (gen_count)
  );

  always #5 clk = ~clk;

  // Keypad matrix: [row line][col line] -> key code
  logic [3:0]  kmap [4][4] = '{'{4'h7, 4'h4, 4'h1, 4'h0},
                               '{4'h8, 4'h5, 4'h2, 4'hA},
                               '{4'h9, 4'h6, 4'h3, 4'hB},
                               '{4'hC, 4'hD, 4'hE, 4'hF}};
  logic [15:0] pressed = '0;

  always_comb begin
    keypadCol = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!keypadRow[r])
        for (int c = 0; c < 4; c++)
          if (pressed[kmap[r][c]]) keypadCol[c] = 1'b0;
  end

  int unsigned      n_chk = 0;
  int unsigned      n_pass = 0;
  int unsigned      cyc = 0;
  int unsigned      req_count = 0;
  int unsigned      req_times[$];
  exp_t             sb[$];
  logic             auto_ok = 1'b0;
  logic             cur_valid = 1'b0;
  logic [1:0]       cur_op = '0;
  logic [3:0]       cur_pat = '0;
  int unsigned      ack_delay = 3;
  logic [GEN_W-1:0] exp_gen = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  initial forever @(posedge clk) cyc++;

  // Request monitor: pop the scoreboard on each new request, then require it held stable.
  initial begin
    exp_t e;
    logic req_prev;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_req && !req_prev) begin
        req_count++;
        req_times.push_back(cyc);
        cur_valid = 1'b1;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          cur_op  = e.op;
          cur_pat = e.pat;
        end else if (auto_ok) begin
          cur_op  = E_STEP;
          cur_pat = '0;
        end else begin
          chk("sb_nonempty", sb.size(), 1);
          cur_valid = 1'b0;
        end
        if (cur_valid) begin
          chk("cmd_op", 32'(cmd_op), 32'(cur_op));
          if (cur_op == E_LOAD) chk("cmd_pattern", 32'(cmd_pattern), 32'(cur_pat));
        end
      end else if (cmd_req && cur_valid) begin
        chk("held_op", 32'(cmd_op), 32'(cur_op));
        if (cur_op == E_LOAD) chk("held_pattern", 32'(cmd_pattern), 32'(cur_pat));
      end
      req_prev = cmd_req;
    end
  end

  // Board responder: ack after ack_delay cycles of cmd_req; models gen_count.
  initial begin
    int unsigned wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (cmd_ack) begin
        cmd_ack = 1'b0;
      end else if (cmd_req && rst) begin
        if (wait_cnt + 1 >= ack_delay) begin
          cmd_ack  = 1'b1;
          wait_cnt = 0;
          exp_gen  = (cur_op == E_STEP) ? exp_gen + GEN_W'(1) : '0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic press(input logic [3:0] code, input int unsigned hold);
    pressed[code] = 1'b1;
    repeat (hold) @(negedge clk);
    pressed[code] = 1'b0;
    repeat (48) @(negedge clk);
  endtask

  task automatic wait_reqs(input int unsigned n, input int unsigned budget);
    int unsigned t;
    t = 0;
    while (req_count < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (req_count < n) chk("wait_reqs", req_count, n);
  endtask

  task automatic wait_low(input int unsigned budget);
    int unsigned t;
    t = 0;
    while ((cmd_req || cmd_ack) && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (cmd_req || cmd_ack) chk("wait_low", 32'(cmd_req), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  rowseq [4];
    logic [2:0]  exp_spd;
    int unsigned base;
    rowseq = '{4'b1110, 4'b0111, 4'b1011, 4'b1101};

    repeat (3) @(negedge clk);
    chk("rst_row", 32'(keypadRow), 32'(4'b1110));
    chk("rst_req", 32'(cmd_req), 0);
    chk("rst_op", 32'(cmd_op), 0);
    chk("rst_pattern", 32'(cmd_pattern), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_speed", 32'(speed), 3);
    chk("rst_gen", 32'(gen_count), 0);
    rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("scan_row", 32'(keypadRow), 32'(rowseq[(k / 4) % 4]));
      @(negedge clk);
    end

    exp_spd = 3'd3;
    for (int i = 0; i < 6; i++) begin
      press(4'hC, 48);
      exp_spd = (exp_spd == 3'd7) ? 3'd7 : exp_spd + 3'd1;
      chk("speed_up", 32'(speed), 32'(exp_spd));
    end

    // Speed 7: slow acks force timer fires to collapse into one pending step
    ack_delay = 120;
    auto_ok   = 1'b1;
    base      = req_count;
    press(4'hA, 48);
    chk("stall_running", 32'(running), 1);
    wait_reqs(base + 1, 400);
    wait_low(400);
    chk("stall_gen_first", 32'(gen_count), 32'(exp_gen));
    chk("stall_gen_one", 32'(gen_count), 1);
    repeat (5) @(negedge clk);
    chk("stall_one_extra", req_count, base + 2);
    chk("stall_extra_busy", 32'(cmd_req), 1);
    ack_delay = 3;
    press(4'hA, 48);
    chk("stall_paused", 32'(running), 0);
    repeat (20) @(negedge clk);
    wait_low(200);
    auto_ok = 1'b0;
    chk("stall_gen_end", 32'(gen_count), 32'(exp_gen));

    for (int i = 0; i < 9; i++) begin
      press(4'hD, 48);
      exp_spd = (exp_spd == 3'd0) ? 3'd0 : exp_spd - 3'd1;
      chk("speed_down", 32'(speed), 32'(exp_spd));
    end
    for (int i = 0; i < 3; i++) begin
      press(4'hC, 48);
      exp_spd = exp_spd + 3'd1;
      chk("speed_back", 32'(speed), 32'(exp_spd));
    end

    sb.push_back('{op: E_LOAD, pat: 4'd5});
    base = req_count;
    press(4'h5, 96);
    wait_low(100);
    chk("load_once", req_count, base + 1);
    chk("load_gen", 32'(gen_count), 32'(exp_gen));
    chk("load_gen_zero", 32'(gen_count), 0);
    chk("load_running", 32'(running), 0);

    req_times.delete();
    base    = req_count;
    auto_ok = 1'b1;
    press(4'hA, 48);
    chk("run_running", 32'(running), 1);
    for (int unsigned i = 1; i <= 3; i++) begin
      wait_reqs(base + i, 200);
      wait_low(50);
      chk("run_gen", 32'(gen_count), i);
    end
    if (req_times.size() >= 3) begin
      chk("run_spacing1", req_times[1] - req_times[0], 50);
      chk("run_spacing2", req_times[2] - req_times[1], 50);
    end else begin
      chk("run_req_times", req_times.size(), 3);
    end
    press(4'hB, 48);
    repeat (110) @(negedge clk);
    chk("run_b_running", 32'(running), 1);
    for (int j = 3; j < req_times.size(); j++)
      chk("run_b_spacing", req_times[j] - req_times[j - 1], 50);
    press(4'hA, 48);
    repeat (20) @(negedge clk);
    wait_low(200);
    auto_ok = 1'b0;
    chk("run_paused", 32'(running), 0);
    chk("run_gen_end", 32'(gen_count), 32'(exp_gen));

    sb.push_back('{op: E_LOAD, pat: 4'd7});
    press(4'h7, 48);
    wait_low(100);
    chk("load7_gen", 32'(gen_count), 0);

    sb.push_back('{op: E_STEP, pat: 4'd0});
    press(4'hB, 48);
    sb.push_back('{op: E_STEP, pat: 4'd0});
    press(4'hB, 48);
    wait_low(100);
    chk("bstep_gen", 32'(gen_count), 2);

    // Clear arrives while a STEP is outstanding
    ack_delay = 1000;
    base      = req_count;
    sb.push_back('{op: E_STEP, pat: 4'd0});
    press(4'hB, 48);
    chk("e_step_busy", 32'(cmd_req), 1);
    sb.push_back('{op: E_CLEAR, pat: 4'd0});
    press(4'hE, 48);
    ack_delay = 3;
    wait_low(20);
    chk("e_step_counted", 32'(gen_count), 3);
    wait_reqs(base + 2, 50);
    wait_low(50);
    chk("e_clear_gen", 32'(gen_count), 0);
    chk("e_clear_model", 32'(gen_count), 32'(exp_gen));

    // Reset while BUSY with a LOAD pending behind it
    ack_delay = 1000;
    base      = req_count;
    sb.push_back('{op: E_STEP, pat: 4'd0});
    press(4'hB, 48);
    chk("rst_step_busy", 32'(cmd_req), 1);
    press(4'h8, 48);
    #2;
    rst     = 1'b0;
    exp_gen = '0;
    #1;
    chk("rst_async_req", 32'(cmd_req), 0);
    chk("rst_async_row", 32'(keypadRow), 32'(4'b1110));
    @(negedge clk);
    rst       = 1'b1;
    ack_delay = 3;
    repeat (100) @(negedge clk);
    chk("rst_discard", req_count, base + 1);
    chk("rst_gen", 32'(gen_count), 0);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
